// File: rtl/jp_scanner_pkg.sv
// Shared definitions for the NES joypad scanner: FSM state encodings and button bit positions.
package jp_scanner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_READ  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } jp_state_t;

  localparam int JP_BTN_A      = 0;
  localparam int JP_BTN_B      = 1;
  localparam int JP_BTN_SELECT = 2;
  localparam int JP_BTN_START  = 3;
  localparam int JP_BTN_UP     = 4;
  localparam int JP_BTN_DOWN   = 5;
  localparam int JP_BTN_LEFT   = 6;
  localparam int JP_BTN_RIGHT  = 7;

  // Phase counter must hold 2*HALF_CYC-1 for the latch phase (HALF_CYC up to 255).
  localparam int CNT_W = 9;

endpackage

// File: rtl/jp_scanner_sync.sv
// jp_sync: 2-flop synchronizer for an asynchronous pad input; reset value is a parameter.
// Latency 2 cycles; no backpressure.
module jp_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_25,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_25) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/jp_scanner.sv
// NES pad poller: latch + 7 shift clocks, 8 bits captured into an active-high button byte.
// Latency poll_in -> valid_out = 1+17*HALF_CYC; a poll while busy is queued once, extras dropped.
// Optional turbo gating of A/B when JP_TURBO_EN is defined.
module jp_scanner
  import jp_scanner_pkg::*;
#(
  parameter int HALF_CYC = 6
`ifdef JP_TURBO_EN
  , parameter int TURBO_DIV = 4
`endif
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       poll_in,
  input  logic       jp_data_in,
  input  logic [1:0] turbo_mask_in,
  output logic       jp_latch_out,
  output logic       jp_clk_out,
  output logic [7:0] buttons_out,
  output logic [7:0] pressed_out,
  output logic       valid_out,
  output logic       busy_out
);

  localparam logic [CNT_W-1:0] HALF_LD  = CNT_W'(HALF_CYC - 1);
  localparam logic [CNT_W-1:0] LATCH_LD = CNT_W'(2 * HALF_CYC - 1);

  jp_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [7:0]       shadow, shadow_nxt;
  logic             pending, pending_nxt;
  logic             data_s;
  logic [7:0]       btn_new;

  jp_sync #(.RST_VAL(1'b1)) u_sync (
    .clk_25 (clk_in),
    .rst    (rst_in),
    .d      (jp_data_in),
    .q      (data_s)
  );

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    shadow_nxt  = shadow;
    pending_nxt = pending;
    if (state != ST_IDLE && poll_in) pending_nxt = 1'b1;
    case (state)
      ST_IDLE: begin
        if (poll_in || pending) begin
          state_nxt   = ST_LATCH;
          cnt_nxt     = LATCH_LD;
          idx_nxt     = '0;
          pending_nxt = 1'b0;
        end
      end
      ST_LATCH: begin
        if (cnt == '0) begin
          state_nxt = ST_READ;
          cnt_nxt   = HALF_LD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_READ: begin
        if (cnt == '0) begin
          // Sample at the end of the low phase so the synchronizer has settled.
          shadow_nxt[idx] = ~data_s;
          cnt_nxt         = HALF_LD;
          state_nxt       = (idx == 3'd7) ? ST_DONE : ST_SHIFT;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (cnt == '0) begin
          state_nxt = ST_READ;
          cnt_nxt   = HALF_LD;
          idx_nxt   = idx + 3'd1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

`ifdef JP_TURBO_EN
  logic [7:0] turbo_cnt;
  logic       turbo_phase;

  always_comb begin
    btn_new = shadow_nxt;
    if (turbo_mask_in[0]) btn_new[JP_BTN_A] = shadow_nxt[JP_BTN_A] & turbo_phase;
    if (turbo_mask_in[1]) btn_new[JP_BTN_B] = shadow_nxt[JP_BTN_B] & turbo_phase;
  end

  // Phase advances after the current poll has been masked with the old phase.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      turbo_cnt   <= '0;
      turbo_phase <= 1'b0;
    end else if (state_nxt == ST_DONE) begin
      if (turbo_cnt == 8'(TURBO_DIV - 1)) begin
        turbo_cnt   <= '0;
        turbo_phase <= ~turbo_phase;
      end else begin
        turbo_cnt <= turbo_cnt + 8'd1;
      end
    end
  end
`else
  logic unused_turbo_mask;
  assign unused_turbo_mask = ^turbo_mask_in;
  assign btn_new = shadow_nxt;
`endif

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      idx          <= '0;
      shadow       <= '0;
      pending      <= 1'b0;
      jp_latch_out <= 1'b0;
      jp_clk_out   <= 1'b0;
      buttons_out  <= '0;
      pressed_out  <= '0;
      valid_out    <= 1'b0;
      busy_out     <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      idx          <= idx_nxt;
      shadow       <= shadow_nxt;
      pending      <= pending_nxt;
      jp_latch_out <= (state_nxt == ST_LATCH);
      jp_clk_out   <= (state_nxt == ST_SHIFT);
      busy_out     <= (state_nxt != ST_IDLE);
      valid_out    <= (state_nxt == ST_DONE);
      if (state_nxt == ST_DONE) begin
        buttons_out <= btn_new;
        pressed_out <= btn_new & ~buttons_out;
      end else begin
        pressed_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_jp_scanner.sv
// Bench for jp_scanner: 4021-style pad model, scoreboard of expected button/pressed bytes per poll.
`timescale 1ns/1ps
module tb_jp_scanner;

  localparam int HALF = 6;
  localparam int LAT  = 1 + 17 * HALF;

  logic       clk_25 = 1'b0;
  logic       rst = 1'b1;
  logic       poll = 1'b0;
  logic       jp_data = 1'b1;
  logic [1:0] tmask = 2'b00;
  logic       latch, jclk, valid, busy;
  logic [7:0] buttons, pressed;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  pad_btn = 8'h00;
  logic        unplugged = 1'b0;
  logic [7:0]  pad_sr = 8'hFF;
  logic        jclk_prev = 1'b0;
  logic        clr_chk = 1'b0;

  always #20 clk_25 = ~clk_25;

  jp_scanner #(
    .HALF_CYC (HALF)
`ifdef JP_TURBO_EN
    , .TURBO_DIV (2)
`endif
  ) dut (
    .clk_in        (clk_25),
    .rst_in        (rst),
    .poll_in       (poll),
    .jp_data_in    (jp_data),
    .turbo_mask_in (tmask),
    .jp_latch_out  (latch),
    .jp_clk_out    (jclk),
    .buttons_out   (buttons),
    .pressed_out   (pressed),
    .valid_out     (valid),
    .busy_out      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Pad model: parallel load while latched, shift towards bit0 on each clock rise, low = pressed.
  always @(negedge clk_25) begin
    if (latch) pad_sr = ~pad_btn;
    else if (jclk && !jclk_prev) pad_sr = {1'b1, pad_sr[7:1]};
    jclk_prev = jclk;
    jp_data = unplugged ? 1'b1 : pad_sr[0];
  end

  // Monitor: pop one expectation per valid strobe; pressed must clear the cycle after.
  always @(negedge clk_25) begin
    logic [15:0] e;
    if (clr_chk) check("pressed_clear", pressed, 8'h00);
    if (valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_valid: got buttons=%0h pressed=%0h, required no strobe", buttons, pressed);
      end else begin
        e = exp_q.pop_front();
        check("buttons", buttons, e[15:8]);
        check("pressed", pressed, e[7:0]);
      end
    end
    clr_chk = valid;
  end

  task automatic tick();
    @(posedge clk_25);
    #1;
  endtask

  task automatic pulse_poll();
    poll = 1'b1;
    tick();
    poll = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      if (valid) begin
        n = i;
        break;
      end
      tick();
    end
  endtask

  task automatic run_poll(input logic [7:0] eb, input logic [7:0] ep);
    int   latch_n = 0;
    int   pulses = 0;
    int   overlap = 0;
    int   lat = 0;
    logic prev = 1'b0;
    exp_q.push_back({eb, ep});
    pulse_poll();
    check("latch_first_cycle", latch, 1'b1);
    check("busy_during_poll", busy, 1'b1);
    for (int n = 1; n <= 300; n++) begin
      if (latch) latch_n++;
      if (jclk && !prev) pulses++;
      if (latch && jclk) overlap++;
      prev = jclk;
      if (valid) begin
        lat = n;
        break;
      end
      tick();
    end
    check("valid_latency", lat, LAT);
    check("latch_cycles", latch_n, 2 * HALF);
    check("clk_pulses", pulses, 7);
    check("latch_clk_overlap", overlap, 0);
    tick();
    check("busy_after_done", busy, 1'b0);
    tick();
  endtask

  initial begin
    int n;
    int cnt;

    // Reset state
    repeat (3) tick();
    check("rst_latch", latch, 1'b0);
    check("rst_clk", jclk, 1'b0);
    check("rst_buttons", buttons, 8'h00);
    check("rst_pressed", pressed, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (3) tick();

    // Start+Up press, hold, release
    pad_btn = 8'h18;
    run_poll(8'h18, 8'h18);
    run_poll(8'h18, 8'h00);
    pad_btn = 8'h00;
    run_poll(8'h00, 8'h00);

    // Three requests during a busy poll collapse into one extra poll
    pad_btn = 8'h81;
    exp_q.push_back({8'h81, 8'h81});
    exp_q.push_back({8'h81, 8'h00});
    pulse_poll();
    repeat (9) tick();
    pulse_poll();
    repeat (40) tick();
    pulse_poll();
    wait_valid(n);
    check("pend_first_done", (n > 0), 1'b1);
    poll = 1'b1;
    tick();
    poll = 1'b0;
    check("pend_idle_latch", latch, 1'b0);
    check("pend_idle_busy", busy, 1'b0);
    tick();
    check("pend_latch_rise", latch, 1'b1);
    wait_valid(n);
    check("pend_second_latency", n, LAT);
    cnt = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (latch) cnt++;
    end
    check("pend_no_third_poll", cnt, 0);

    // Reset during bit-4 READ
    pad_btn = 8'h42;
    pulse_poll();
    cnt = 0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (jclk && !n[0]) cnt++;
      n[0] = jclk;
      if (cnt == 4 && !jclk) break;
      tick();
    end
    check("midrst_reached_bit4", cnt, 4);
    tick();
    rst = 1'b1;
    tick();
    check("midrst_latch", latch, 1'b0);
    check("midrst_clk", jclk, 1'b0);
    check("midrst_buttons", buttons, 8'h00);
    check("midrst_pressed", pressed, 8'h00);
    check("midrst_valid", valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (latch || jclk || busy) cnt++;
    end
    check("midrst_stays_idle", cnt, 0);
    run_poll(8'h42, 8'h42);

    // Unplugged pad reads as nothing pressed
    unplugged = 1'b1;
    run_poll(8'h00, 8'h00);
    run_poll(8'h00, 8'h00);
    unplugged = 1'b0;

`ifdef JP_TURBO_EN
    // Turbo on A with two polls per phase
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tmask = 2'b01;
    pad_btn = 8'h01;
    run_poll(8'h00, 8'h00);
    run_poll(8'h00, 8'h00);
    run_poll(8'h01, 8'h01);
    run_poll(8'h01, 8'h00);
    run_poll(8'h00, 8'h00);
    run_poll(8'h00, 8'h00);
    tmask = 2'b00;
`endif

    repeat (5) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
